// File: rtl/aes_pkg.sv
// Shared types and constants for the iterative AES-128 decryption path.
package aes_pkg;

  localparam int NR    = 10;
  localparam int BLK_W = 128;
  localparam int RK_W  = 4;

  localparam logic [RK_W-1:0] RK_LAST = RK_W'(NR);

  typedef logic [0:BLK_W-1] aes_state_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } ictrl_state_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

endpackage

// File: rtl/InvMixColumns.sv
// Combinational InvMixColumns over a column-major 128-bit state (byte 0 = bits [0:7]).
module InvMixColumns
  import aes_pkg::*;
(
  input  logic [0:BLK_W-1] message,
  output logic [0:BLK_W-1] crypte
);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m09(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] m0b(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] m0d(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] m0e(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign a0 = message[32*c      +: 8];
    assign a1 = message[32*c + 8  +: 8];
    assign a2 = message[32*c + 16 +: 8];
    assign a3 = message[32*c + 24 +: 8];

    assign crypte[32*c      +: 8] = m0e(a0) ^ m0b(a1) ^ m0d(a2) ^ m09(a3);
    assign crypte[32*c + 8  +: 8] = m09(a0) ^ m0e(a1) ^ m0b(a2) ^ m0d(a3);
    assign crypte[32*c + 16 +: 8] = m0d(a0) ^ m09(a1) ^ m0e(a2) ^ m0b(a3);
    assign crypte[32*c + 24 +: 8] = m0b(a0) ^ m0d(a1) ^ m09(a2) ^ m0e(a3);
  end

endmodule

// File: rtl/aes_inv_sub_shift.sv
// Combinational InvShiftRows followed by a per-byte inverse S-box lookup.
module aes_inv_sub_shift
  import aes_pkg::*;
(
  input  logic [0:BLK_W-1] state_i,
  output logic [0:BLK_W-1] state_o
);

  // Row r rotates right by r columns: output column c takes input column (c - r) mod 4.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      assign state_o[8*(r + 4*c) +: 8] = inv_sbox(state_i[8*(r + 4*((c + 4 - r) % 4)) +: 8]);
    end
  end

endmodule

// File: rtl/aes128_inv_round_ctrl.sv
// Iterative AES-128 decryption sequencer: one inverse round per clock, keys fetched by index.
//   IDLE  | waiting for ciphertext, rk_idx=10 | ROUND | inverse rounds 9..1, rk_idx=round
//   FINAL | last round without InvMixColumns  | DONE  | plaintext held until out_ready
module aes128_inv_round_ctrl
  import aes_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:BLK_W-1] in_data,
  output logic [RK_W-1:0]  rk_idx,
  input  logic [0:BLK_W-1] rk_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:BLK_W-1] out_data,
  output logic             busy
);

  ictrl_state_e    st_q, st_d;
  logic [RK_W-1:0] round_q, round_d;
  aes_state_t      data_q, data_d;
  aes_state_t      sub_shift_w, mix_in_w, mix_out_w;

  aes_inv_sub_shift u_sub_shift (
    .state_i (data_q),
    .state_o (sub_shift_w)
  );

  assign mix_in_w = sub_shift_w ^ rk_data;

  InvMixColumns u_inv_mix (
    .message (mix_in_w),
    .crypte  (mix_out_w)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= ST_IDLE;
      round_q <= '0;
      data_q  <= '0;
    end else begin
      st_q    <= st_d;
      round_q <= round_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    st_d      = st_q;
    round_d   = round_q;
    data_d    = data_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_idx    = RK_LAST;
    case (st_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && !flush) begin
          data_d  = in_data ^ rk_data;
          round_d = RK_LAST - RK_W'(1);
          st_d    = ST_ROUND;
        end
      end
      ST_ROUND: begin
        busy   = 1'b1;
        rk_idx = round_q;
        data_d = mix_out_w;
        if (round_q == RK_W'(1)) begin
          st_d = ST_FINAL;
        end else begin
          round_d = round_q - RK_W'(1);
        end
      end
      ST_FINAL: begin
        busy   = 1'b1;
        rk_idx = '0;
        data_d = mix_in_w;
        st_d   = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          st_d = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
    // Abort keeps the datapath contents; only the sequencing is dropped.
    if (flush) begin
      st_d    = ST_IDLE;
      round_d = round_q;
      data_d  = data_q;
    end
  end

  assign out_data = data_q;

endmodule

// File: tb/tb_aes128_inv_round_ctrl.sv
// Bench for aes128_inv_round_ctrl: forward-cipher reference model builds ciphertexts from plaintexts.
module tb_aes128_inv_round_ctrl;

  logic         clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [0:127] in_data, rk_data, out_data;
  logic [3:0]   rk_idx;

  logic [0:127] ks [0:10];
  logic [7:0]   sbox_t [256];
  int           total = 0;
  int           bad   = 0;

  typedef struct {
    logic [0:127] key;
    logic [0:127] ct;
    logic [0:127] pt;
  } vec_t;

  localparam int NV = 6;
  vec_t vecs [NV];

  localparam logic [0:127] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [0:127] C1_PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] C1_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  aes128_inv_round_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rk_idx    (rk_idx),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    rk_data = '0;
    if (rk_idx <= 4'd10) rk_data = ks[rk_idx];
  end

  // ---------------- reference model (forward AES-128) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] b;
    for (int x = 0; x < 256; x++) begin
      b = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      sbox_t[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [0:127] round_key(input logic [0:127] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [0:127] sub_shift_fwd(input logic [0:127] s);
    logic [0:127] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(r + 4*c) +: 8] = sbox_t[s[8*(r + 4*((c + r) % 4)) +: 8]];
    return o;
  endfunction

  function automatic logic [0:127] mix_fwd(input logic [0:127] s);
    logic [0:127] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8]; a1 = s[32*c+8 +: 8]; a2 = s[32*c+16 +: 8]; a3 = s[32*c+24 +: 8];
      o[32*c    +: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[32*c+8  +: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[32*c+16 +: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[32*c+24 +: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [0:127] aes_enc(input logic [0:127] key, input logic [0:127] pt);
    logic [0:127] s;
    s = pt ^ round_key(key, 0);
    for (int r = 1; r < 10; r++) s = mix_fwd(sub_shift_fwd(s)) ^ round_key(key, r);
    return sub_shift_fwd(s) ^ round_key(key, 10);
  endfunction

  task automatic set_keys(input logic [0:127] key);
    for (int r = 0; r <= 10; r++) ks[r] = round_key(key, r);
  endtask

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checking helpers ----------------
  function automatic logic [135:0] fl(input logic [3:0] r, input logic rdy, input logic vld, input logic bsy);
    return {129'd0, r, rdy, vld, bsy};
  endfunction

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one block, trace rk_idx every cycle, optionally stall the output, then drain it.
  task automatic run_block(input logic [0:127] ct, input logic [0:127] pt, input string nm, input int hold);
    logic [3:0] exp_rk;
    chk($sformatf("%s idle", nm), fl(rk_idx, in_ready, out_valid, busy), fl(4'd10, 1'b1, 1'b0, 1'b0));
    in_valid = 1'b1;
    in_data  = ct;
    step();
    in_valid = 1'b0;
    in_data  = rnd128();
    for (int k = 0; k < 10; k++) begin
      exp_rk = (k < 9) ? 4'(9 - k) : 4'd0;
      chk($sformatf("%s cyc%0d", nm, k), fl(rk_idx, in_ready, out_valid, busy), fl(exp_rk, 1'b0, 1'b0, 1'b1));
      step();
    end
    chk($sformatf("%s done", nm), fl(rk_idx, in_ready, out_valid, busy), fl(4'd10, 1'b0, 1'b1, 1'b0));
    chk($sformatf("%s data", nm), {8'd0, out_data}, {8'd0, pt});
    for (int h = 0; h < hold; h++) begin
      in_valid = h[0];
      in_data  = rnd128();
      step();
      chk($sformatf("%s hold%0d", nm, h), {6'd0, out_valid, in_ready, out_data}, {6'd0, 1'b1, 1'b0, pt});
    end
    in_valid  = (hold > 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk($sformatf("%s drained", nm), fl(rk_idx, in_ready, out_valid, busy), fl(4'd10, 1'b1, 1'b0, 1'b0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:127] pt_b, ct_b, outs [2];
    int           acc_cyc [2], hs_cyc [2];
    int           nacc, nout;
    logic         acc_now, hs_now;

    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    build_sbox();

    vecs[0].key = C1_KEY; vecs[0].ct = C1_CT; vecs[0].pt = C1_PT;
    for (int i = 1; i < NV; i++) begin
      vecs[i].key = rnd128();
      vecs[i].pt  = rnd128();
      vecs[i].ct  = aes_enc(vecs[i].key, vecs[i].pt);
    end

    chk("model c1 ct", {8'd0, aes_enc(C1_KEY, C1_PT)}, {8'd0, C1_CT});
    chk("model c1 rk10", {8'd0, round_key(C1_KEY, 10)}, {8'd0, C1_RK10});
    set_keys(C1_KEY);

    #1 rst_n = 1'b0;
    #2;
    chk("reset flags", fl(rk_idx, in_ready, out_valid, busy), fl(4'd10, 1'b1, 1'b0, 1'b0));
    chk("reset data", {8'd0, out_data}, 136'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < NV; i++) begin
      set_keys(vecs[i].key);
      run_block(vecs[i].ct, vecs[i].pt, $sformatf("vec%0d", i), 0);
    end

    set_keys(C1_KEY);
    run_block(C1_CT, C1_PT, "bp", 20);

    // Back-to-back with in_valid held high and out_ready always asserted.
    pt_b = rnd128();
    ct_b = aes_enc(C1_KEY, pt_b);
    nacc = 0; nout = 0;
    acc_cyc = '{0, 0}; hs_cyc = '{0, 0}; outs = '{128'd0, 128'd0};
    in_valid = 1'b1; in_data = C1_CT; out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && nout < 2; cyc++) begin
      acc_now = in_valid && in_ready;
      hs_now  = out_valid && out_ready;
      if (hs_now) begin
        outs[nout]   = out_data;
        hs_cyc[nout] = cyc;
        nout++;
      end
      if (acc_now && nacc < 2) begin
        acc_cyc[nacc] = cyc;
        nacc++;
      end
      step();
      if (acc_now) begin
        if (nacc == 1) in_data = ct_b;
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk_i("b2b accepts", nacc, 2);
    chk_i("b2b outputs", nout, 2);
    chk("b2b data0", {8'd0, outs[0]}, {8'd0, C1_PT});
    chk("b2b data1", {8'd0, outs[1]}, {8'd0, pt_b});
    chk_i("b2b latency", hs_cyc[0] - acc_cyc[0], 11);
    chk_i("b2b accept after handshake", int'(acc_cyc[1] - hs_cyc[0] >= 1), 1);
    chk_i("b2b spacing", int'(acc_cyc[1] - acc_cyc[0] >= 12), 1);
    step();

    // Flush while round 5 is being processed.
    in_valid = 1'b1; in_data = C1_CT;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("flush at round5", fl(rk_idx, in_ready, out_valid, busy), fl(4'd5, 1'b0, 1'b0, 1'b1));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush idle", fl(rk_idx, in_ready, out_valid, busy), fl(4'd10, 1'b1, 1'b0, 1'b0));
    flush = 1'b1; in_valid = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush blocks accept", fl(rk_idx, in_ready, out_valid, busy), fl(4'd10, 1'b1, 1'b0, 1'b0));
    run_block(C1_CT, C1_PT, "post flush", 0);

    // Flush while the result is waiting drops out_valid.
    in_valid = 1'b1; in_data = C1_CT;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("done before flush", fl(rk_idx, in_ready, out_valid, busy), fl(4'd10, 1'b0, 1'b1, 1'b0));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush from done", fl(rk_idx, in_ready, out_valid, busy), fl(4'd10, 1'b1, 1'b0, 1'b0));

    // Asynchronous reset between edges in the middle of the rounds.
    in_valid = 1'b1; in_data = C1_CT;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) step();
    #3 rst_n = 1'b0;
    #1;
    chk("async rst flags", fl(rk_idx, in_ready, out_valid, busy), fl(4'd10, 1'b1, 1'b0, 1'b0));
    chk("async rst data", {8'd0, out_data}, 136'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    run_block(C1_CT, C1_PT, "post reset", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
